// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: synchronizes and debounces a two-road light bus, tracks legal phases, and flags sequencing errors (timeout check built only with MONITOR_TIMEOUT_EN).
module traffic_light_monitor #(
  parameter int STABLE_CYCLES  = 4,
  parameter int MIN_DWELL      = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int DWELL_W        = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               enable,
  input  logic [5:0]         lights_i,
  input  logic               clear_i,
  output logic [2:0]         phase_o,
  output logic               phase_valid_o,
  output logic               change_o,
  output logic [DWELL_W-1:0] dwell_o,
  output logic [3:0]         err_o,
  output logic [7:0]         err_count_o
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] SC = CW'(STABLE_CYCLES);
  localparam logic [DWELL_W-1:0] MIN_DV = DWELL_W'(MIN_DWELL);
  localparam logic [1:0] IDLE = 2'd0, ACQUIRE = 2'd1, TRACK = 2'd2;
  // bit (from*5 + to) set for each permitted phase transition
  localparam logic [31:0] TRANS_OK = 32'h0089_89AA;

  logic [5:0] s1_q, s2_q, cand_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] state_q, state_d;
  logic [2:0] phase_q, phase_d, code;
  logic change_q, diff, fire, legal, is_change, ev;
  logic e_state, e_trans, e_min, e_to;
  logic [4:0] idx;
  logic [DWELL_W-1:0] dwell_q, dwell_d, dwell_inc, dwell_o_q, dwell_o_d;
  logic [3:0] err_q, err_d, new_err;
  logic [7:0] ecnt_q, ecnt_d;

  function automatic logic [2:0] enc(input logic [5:0] v);
    return v == 6'b001001 ? 3'd0 :
           v == 6'b010001 ? 3'd1 :
           v == 6'b100001 ? 3'd2 :
           v == 6'b001010 ? 3'd3 :
           v == 6'b001100 ? 3'd4 : 3'd7;
  endfunction

  // fire is a one-cycle strobe when the synchronized value has held STABLE_CYCLES samples
  assign diff  = s2_q != cand_q;
  assign cnt_d = diff ? CW'(1) : (cnt_q == SC ? cnt_q : cnt_q + 1'b1);
  assign fire  = (diff || cnt_q != SC) && cnt_d == SC;
  assign code  = enc(s2_q);
  assign legal = code != 3'd7;
  assign idx   = {2'b0, phase_q} * 5'd5 + {2'b0, code};

  assign dwell_inc = &dwell_q ? dwell_q : dwell_q + 1'b1;
  assign is_change = enable && state_q == TRACK && fire && legal && code != phase_q;
  assign e_state   = enable && state_q != IDLE && fire && !legal;
  assign e_trans   = is_change && !TRANS_OK[idx];
  assign e_min     = is_change && dwell_inc < MIN_DV;
  assign new_err   = {e_to, e_min, e_trans, e_state};
  assign ev        = |new_err;

  assign state_d = !enable ? IDLE :
                   state_q == IDLE ? ACQUIRE :
                   (fire && !legal) ? ACQUIRE :
                   (fire && state_q == ACQUIRE) ? TRACK : state_q;
  assign phase_d   = state_d == TRACK ? (fire && legal ? code : phase_q) : 3'd7;
  assign dwell_d   = (state_q == TRACK && state_d == TRACK && !is_change) ? dwell_inc : '0;
  assign dwell_o_d = is_change ? dwell_inc : dwell_o_q;
  assign err_d     = (clear_i ? 4'b0 : err_q) | new_err;
  assign ecnt_d    = clear_i ? {7'd0, ev} : ecnt_q + {7'd0, ev && ecnt_q != 8'hFF};

`ifdef MONITOR_TIMEOUT_EN
  localparam logic [DWELL_W-1:0] TO_VAL = DWELL_W'(TIMEOUT_CYCLES);
  logic to_seen_q;
  assign e_to = enable && state_q == TRACK && !is_change && !(fire && !legal) &&
                !to_seen_q && dwell_inc == TO_VAL;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) to_seen_q <= 1'b0;
    else to_seen_q <= state_q == TRACK && state_d == TRACK && !is_change && (to_seen_q || e_to);
  end
`else
  assign e_to = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1_q      <= '0;
      s2_q      <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      state_q   <= IDLE;
      phase_q   <= 3'd7;
      change_q  <= 1'b0;
      dwell_q   <= '0;
      dwell_o_q <= '0;
      err_q     <= '0;
      ecnt_q    <= '0;
    end else begin
      s1_q      <= lights_i;
      s2_q      <= s1_q;
      cand_q    <= enable ? s2_q : '0;
      cnt_q     <= enable ? cnt_d : '0;
      state_q   <= state_d;
      phase_q   <= phase_d;
      change_q  <= is_change;
      dwell_q   <= dwell_d;
      dwell_o_q <= dwell_o_d;
      err_q     <= err_d;
      ecnt_q    <= ecnt_d;
    end
  end

  assign phase_o       = phase_q;
  assign phase_valid_o = state_q == TRACK;
  assign change_o      = change_q;
  assign dwell_o       = dwell_o_q;
  assign err_o         = err_q;
  assign err_count_o   = ecnt_q;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: table-driven phase sequences plus hand-written clear, saturation, enable and timeout cases.
module tb_traffic_light_monitor;
  localparam logic [5:0] S0 = 6'b001001, S1 = 6'b010001, S2 = 6'b100001,
                         S3 = 6'b001010, S4 = 6'b001100, SX = 6'b000000;

  typedef struct {
    logic [5:0]  l;
    logic        clr;
    int          n;
    logic [2:0]  ph;
    logic        v;
    logic [3:0]  err;
    logic [7:0]  cnt;
    int          chg;
    logic [15:0] dw;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, clear = 1'b0;
  logic [5:0] lights = '0;
  logic [2:0] phase;
  logic valid, change;
  logic [15:0] dwell;
  logic [3:0] err;
  logic [7:0] ecnt;
  int checks = 0, errors = 0, chg_cnt = 0, c0;
  logic [3:0] to_err;
  logic [7:0] to_cnt;
  vec_t tbl[19];

  traffic_light_monitor #(.TIMEOUT_CYCLES(100)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable), .lights_i(lights), .clear_i(clear),
    .phase_o(phase), .phase_valid_o(valid), .change_o(change), .dwell_o(dwell),
    .err_o(err), .err_count_o(ecnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (change === 1'b1) chg_cnt = chg_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{S0, 1'b0, 40, 3'd0, 1'b1, 4'b0000, 8'd0, 0, 16'd0};
    tbl[1]  = '{S1, 1'b0, 40, 3'd1, 1'b1, 4'b0000, 8'd0, 1, 16'd40};
    tbl[2]  = '{S2, 1'b0, 40, 3'd2, 1'b1, 4'b0000, 8'd0, 1, 16'd40};
    tbl[3]  = '{S1, 1'b0, 40, 3'd1, 1'b1, 4'b0000, 8'd0, 1, 16'd40};
    tbl[4]  = '{S3, 1'b0, 40, 3'd3, 1'b1, 4'b0000, 8'd0, 1, 16'd40};
    tbl[5]  = '{S4, 1'b0, 40, 3'd4, 1'b1, 4'b0000, 8'd0, 1, 16'd40};
    tbl[6]  = '{S3, 1'b0, 40, 3'd3, 1'b1, 4'b0000, 8'd0, 1, 16'd40};
    tbl[7]  = '{S1, 1'b0, 40, 3'd1, 1'b1, 4'b0000, 8'd0, 1, 16'd40};
    tbl[8]  = '{S2, 1'b0, 40, 3'd2, 1'b1, 4'b0000, 8'd0, 1, 16'd40};
    tbl[9]  = '{S4, 1'b0, 40, 3'd4, 1'b1, 4'b0010, 8'd1, 1, 16'd40};
    tbl[10] = '{SX, 1'b0, 40, 3'd7, 1'b0, 4'b0011, 8'd2, 0, 16'd40};
    tbl[11] = '{S0, 1'b0, 40, 3'd0, 1'b1, 4'b0011, 8'd2, 0, 16'd40};
    tbl[12] = '{S0, 1'b1, 2,  3'd0, 1'b1, 4'b0000, 8'd0, 0, 16'd40};
    tbl[13] = '{S1, 1'b0, 40, 3'd1, 1'b1, 4'b0000, 8'd0, 1, 16'd42};
    tbl[14] = '{S2, 1'b0, 40, 3'd2, 1'b1, 4'b0000, 8'd0, 1, 16'd40};
    tbl[15] = '{S1, 1'b0, 3,  3'd2, 1'b1, 4'b0000, 8'd0, 0, 16'd40};
    tbl[16] = '{S2, 1'b0, 37, 3'd2, 1'b1, 4'b0000, 8'd0, 0, 16'd40};
    tbl[17] = '{S1, 1'b0, 10, 3'd1, 1'b1, 4'b0000, 8'd0, 1, 16'd80};
    tbl[18] = '{S2, 1'b0, 40, 3'd2, 1'b1, 4'b0100, 8'd1, 1, 16'd10};
`ifdef MONITOR_TIMEOUT_EN
    to_err = 4'b1000; to_cnt = 8'd1;
`else
    to_err = 4'b0000; to_cnt = 8'd0;
`endif

    step(3);
    chk("rst_phase", 32'(phase), 32'd7);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_change", 32'(change), 32'd0);
    chk("rst_dwell", 32'(dwell), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cnt", 32'(ecnt), 32'd0);
    rst = 1'b0;
    step(2);

    enable = 1'b1;
    for (int i = 0; i < 19; i++) begin
      lights = tbl[i].l;
      clear = tbl[i].clr;
      c0 = chg_cnt;
      step(tbl[i].n);
      chk($sformatf("r%0d_phase", i), 32'(phase), 32'(tbl[i].ph));
      chk($sformatf("r%0d_valid", i), 32'(valid), 32'(tbl[i].v));
      chk($sformatf("r%0d_err", i), 32'(err), 32'(tbl[i].err));
      chk($sformatf("r%0d_cnt", i), 32'(ecnt), 32'(tbl[i].cnt));
      chk($sformatf("r%0d_changes", i), 32'(chg_cnt - c0), 32'(tbl[i].chg));
      chk($sformatf("r%0d_dwell", i), 32'(dwell), 32'(tbl[i].dw));
    end
    clear = 1'b0;

    // clear coincides with the accept edge of an illegal S2->S4 change
    lights = S4;
    step(5);
    chk("latency_pre_accept", 32'(phase), 32'd2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_same_err", 32'(err), 32'b0010);
    chk("clr_same_cnt", 32'(ecnt), 32'd1);
    chk("clr_same_phase", 32'(phase), 32'd4);

    for (int i = 0; i < 300; i++) begin
      lights = (i % 2 == 0) ? S2 : S4;
      step(8);
      if (i == 199) chk("sat_mid_cnt", 32'(ecnt), 32'd201);
    end
    chk("sat_cnt", 32'(ecnt), 32'd255);
    chk("sat_err", 32'(err), 32'b0110);

    enable = 1'b0;
    lights = S2;
    step(2);
    chk("dis_phase", 32'(phase), 32'd7);
    chk("dis_valid", 32'(valid), 32'd0);
    chk("dis_err_kept", 32'(err), 32'b0110);
    chk("dis_cnt_kept", 32'(ecnt), 32'd255);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_cnt", 32'(ecnt), 32'd0);

    enable = 1'b1;
    c0 = chg_cnt;
    step(250);
    chk("to_phase", 32'(phase), 32'd2);
    chk("to_valid", 32'(valid), 32'd1);
    chk("to_err", 32'(err), 32'(to_err));
    chk("to_cnt", 32'(ecnt), 32'(to_cnt));
    chk("to_changes", 32'(chg_cnt - c0), 32'd0);

    rst = 1'b1;
    step(1);
    chk("midrst_phase", 32'(phase), 32'd7);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_dwell", 32'(dwell), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_cnt", 32'(ecnt), 32'd0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 4: number of cycles the synchronized lights value must hold before it is accepted.
REQ-002 The module SHALL have parameter MIN_DWELL, default 16: minimum legal number of cycles per phase.
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 65535: stuck-phase limit in cycles.
REQ-004 The module SHALL have parameter DWELL_W, default 16: width of the dwell counter.
REQ-005 The module SHALL have port wb_clk_i, input, 1 bit: the only clock.
REQ-006 The module SHALL have port wb_rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 The module SHALL have port enable, input, 1 bit: monitor enable.
REQ-008 The module SHALL have port lights_i, input, 6 bits: [5:3] road A, [2:0] road B, each one-hot {G,Y,R}.
REQ-009 The module SHALL have port clear_i, input, 1 bit: clears sticky errors and the error count.
REQ-010 The module SHALL have port phase_o, output, 3 bits: encoded accepted phase (0-4), or 7 when no phase is valid.
REQ-011 The module SHALL have port phase_valid_o, output, 1 bit: high in TRACK.
REQ-012 The module SHALL have port change_o, output, 1 bit: one-cycle pulse on each accepted phase change.
REQ-013 The module SHALL have port dwell_o, output, DWELL_W bits: dwell length of the phase just left.
REQ-014 The module SHALL have port err_o, output, 4 bits: sticky flags {timeout, min_dwell, illegal_trans, illegal_state}.
REQ-015 The module SHALL have port err_count_o, output, 8 bits: saturating count of error events.

Function
REQ-016 Legal phases SHALL be S0=001001 (all red), S1=010001 (A yellow), S2=100001 (A green), S3=001010 (B yellow), S4=001100 (B green); every other value is illegal.
REQ-017 Legal transitions SHALL be S0->S1, S0->S3, S1->S2, S2->S1, S1->S3, S3->S4, S4->S3, S3->S1, S1->S0 and S3->S0; every other transition is illegal.
REQ-018 lights_i SHALL pass through a 2-flop synchronizer and then a stability filter, so that a held change is accepted exactly STABLE_CYCLES+2 edges after it is applied; changes held for fewer cycles SHALL be ignored.
REQ-019 The FSM SHALL have states IDLE, ACQUIRE and TRACK.
REQ-020 IDLE->ACQUIRE SHALL occur when enable=1.
REQ-021 In ACQUIRE, an accepted legal phase SHALL move the FSM to TRACK with no transition or dwell check.
REQ-022 In TRACK, each accepted change SHALL pulse change_o, load dwell_o with the dwell counter, and clear the counter.
REQ-023 The dwell counter SHALL increment every TRACK cycle and saturate at all-ones.
REQ-024 An accepted illegal value in ACQUIRE or TRACK SHALL set err_o[0] and force ACQUIRE, with phase_o=7.
REQ-025 An accepted legal value forming an illegal transition SHALL set err_o[1] and stay in TRACK on the new phase.
REQ-026 A legal change with dwell < MIN_DWELL SHALL set err_o[2].
REQ-027 Each accept event with any error SHALL increment err_count_o by exactly 1, even when multiple flags set, and SHALL saturate at 255.
REQ-028 clear_i SHALL clear err_o and err_count_o; if an error event occurs in the same cycle, the new flags SHALL be set and the count SHALL be 1.
REQ-029 enable=0 SHALL return the FSM to IDLE the next edge, clear the dwell counter and filter, and set phase_valid_o=0 and phase_o=7; err_o and err_count_o SHALL be retained.

Reset
REQ-030 wb_rst_i=1 at an edge SHALL reset all state, including mid-filter and mid-phase.
REQ-031 After reset, the FSM SHALL be in IDLE with phase_o=7, phase_valid_o=0, change_o=0, dwell_o=0, err_o=0, err_count_o=0, and synchronizers at 0.

Configuration
REQ-032 With MONITOR_TIMEOUT_EN defined, reaching dwell = TIMEOUT_CYCLES in TRACK SHALL set err_o[3] and count one error event, at most once per phase.
REQ-033 Without MONITOR_TIMEOUT_EN, err_o[3] SHALL be constant 0 and no timeout logic SHALL be present.

Verification
REQ-034 Reset, enable=1, then the sequence S0,S1,S2,S1,S3,S4,S3,S1, each held 40 cycles -> 7 change_o pulses; dwell_o=40 at each change after the first; err_o=0.
REQ-035 In TRACK on S2, drive S4 for 40 cycles -> err_o=0010, err_count_o=1, phase_o=4.
REQ-036 Drive 000000 for 40 cycles -> err_o[0]=1, phase_o=7, phase_valid_o=0; then S0 held 40 cycles -> TRACK resumes.
REQ-037 Apply a 3-cycle glitch S1 inside S2 -> no change_o pulse; S1 held 10 cycles -> err_o[2]=1 with dwell_o=10.
REQ-038 Assert clear_i in the same cycle as an illegal-transition accept -> err_o=0010, err_count_o=1; 300 error events -> err_count_o=255.
REQ-039 With MONITOR_TIMEOUT_EN and TIMEOUT_CYCLES=100, hold S2 for 250 cycles -> err_o[3] set once and err_count_o=1; without the macro -> err_o=0.
